nibble_rx: RTL and testbench

Serial-to-parallel front end for the 4-bit code converter stage. It receives framed serial nibbles on a single line and checks parity and stop bit. Each good nibble is held in a one-entry output buffer and handed downstream with a valid/ready handshake. The buffered nibble drives the converter's 4-bit input directly.

---
 rtl/nibble_rx.sv | 130 +++++++++++++
 tb/tb_nibble_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_rx.sv
// rtl/nibble_rx.sv - framed serial nibble receiver with parity/stop checks and a one-entry output buffer
module nibble_rx #(
  parameter bit PARITY_ODD     = 1'b0,
  parameter bit DATA_MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       sdi,
  output logic [3:0] nib_out,
  output logic       nib_valid,
  input  logic       nib_ready,
  output logic       par_err,
  output logic       frm_err,
  output logic       ovr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] shift_q, shift_d;
  logic [1:0] cnt_q, cnt_d;
  logic       par_bad_q, par_bad_d;
  logic [3:0] nib_q, nib_d;
  logic       valid_q, valid_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_err_q, ovr_err_d;
  logic       stop_evt;
  logic       buf_free;
  logic       load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bit_en && !sdi) state_d = S_DATA;
      S_DATA:  if (bit_en && (cnt_q == 2'd3)) state_d = S_PAR;
      S_PAR:   if (bit_en) state_d = S_STOP;
      S_STOP:  if (bit_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_bad_d = par_bad_q;
    stop_evt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bit_en && !sdi) cnt_d = 2'd0;
      end
      S_DATA: begin
        if (bit_en) begin
          shift_d = DATA_MSB_FIRST ? {shift_q[2:0], sdi} : {sdi, shift_q[3:1]};
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_PAR: begin
        if (bit_en) par_bad_d = (((^shift_q) ^ sdi) != PARITY_ODD);
      end
      S_STOP: begin
        stop_evt = bit_en;
      end
      default: begin
        stop_evt = 1'b0;
      end
    endcase
  end

  // Priority on the stop strobe: framing, then parity, then buffer availability.
  assign buf_free  = !valid_q || nib_ready;
  assign load      = stop_evt && sdi && !par_bad_q && buf_free;
  assign frm_err_d = stop_evt && !sdi;
  assign par_err_d = stop_evt && sdi && par_bad_q;
  assign ovr_err_d = stop_evt && sdi && !par_bad_q && !buf_free;

  always_comb begin
    nib_d   = nib_q;
    valid_d = valid_q;
    if (load) begin
      nib_d   = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && nib_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= 4'h0;
      cnt_q     <= 2'd0;
      par_bad_q <= 1'b0;
      nib_q     <= 4'h0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_bad_q <= par_bad_d;
      nib_q     <= nib_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign nib_out   = nib_q;
  assign nib_valid = valid_q;
  assign par_err   = par_err_q;
  assign frm_err   = frm_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_nibble_rx.sv
// tb/tb_nibble_rx.sv - randomized self-checking bench for nibble_rx against a frame-level model
module tb_nibble_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       sdi = 1'b1;
  logic       nib_ready = 1'b0;
  logic [3:0] nib_out, nib_out_m;
  logic       nib_valid, nib_valid_m;
  logic       par_err, frm_err, ovr_err;
  logic       par_err_m, frm_err_m, ovr_err_m;

  always #5 clk = ~clk;

  nibble_rx #(.PARITY_ODD(1'b0), .DATA_MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
    .nib_out(nib_out), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .par_err(par_err), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  nibble_rx #(.PARITY_ODD(1'b0), .DATA_MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
    .nib_out(nib_out_m), .nib_valid(nib_valid_m), .nib_ready(nib_ready),
    .par_err(par_err_m), .frm_err(frm_err_m), .ovr_err(ovr_err_m)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Frame-level reference: collect the six bits after a start bit, then judge the frame.
  logic       in_frame = 1'b0;
  logic       fbits[$];
  logic       m_valid = 1'b0;
  logic [3:0] m_nib = 4'h0;
  logic [3:0] m_nib_msb = 4'h0;
  logic       e_par = 1'b0, e_frm = 1'b0, e_ovr = 1'b0;
  int         pulse_diff = 0;
  int         n_par = 0, n_frm = 0, n_ovr = 0;
  int         valid_cycles = 0;
  logic [3:0] acc_q[$];
  logic [3:0] acc_msb_q[$];

  task automatic step(input logic be, input logic d, input logic rdy, input logic rst);
    logic [3:0] dl, dm;
    logic       ld;
    if (nib_valid && rdy && rst) begin
      acc_q.push_back(nib_out);
      acc_msb_q.push_back(nib_out_m);
    end
    bit_en = be; sdi = d; nib_ready = rdy; rst_n = rst;
    @(posedge clk);
    dl = 4'h0; dm = 4'h0; ld = 1'b0;
    e_par = 1'b0; e_frm = 1'b0; e_ovr = 1'b0;
    if (!rst) begin
      in_frame = 1'b0; fbits.delete();
      m_valid = 1'b0; m_nib = 4'h0; m_nib_msb = 4'h0;
    end else begin
      if (be) begin
        if (!in_frame) begin
          if (!d) begin in_frame = 1'b1; fbits.delete(); end
        end else begin
          fbits.push_back(d);
          if (fbits.size() == 6) begin
            in_frame = 1'b0;
            for (int i = 0; i < 4; i++) begin
              dl[i] = fbits[i];
              dm[3-i] = fbits[i];
            end
            if (!fbits[5]) e_frm = 1'b1;
            else if (((^dl) ^ fbits[4]) != 1'b0) e_par = 1'b1;
            else if (!m_valid || rdy) ld = 1'b1;
            else e_ovr = 1'b1;
          end
        end
      end
      if (ld) begin
        m_valid = 1'b1; m_nib = dl; m_nib_msb = dm;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (par_err !== e_par || frm_err !== e_frm || ovr_err !== e_ovr) pulse_diff++;
    if (par_err === 1'b1) n_par++;
    if (frm_err === 1'b1) n_frm++;
    if (ovr_err === 1'b1) n_ovr++;
    if (nib_valid === 1'b1) valid_cycles++;
  endtask

  // rmode 0: nib_ready = rdy_body except rdy_stop on the stop bit; rmode 1: random each cycle.
  task automatic send_frame(input logic [3:0] data, input logic par_flip, input logic stop,
                            input int max_gap, input int rmode, input logic rdy_body,
                            input logic rdy_stop);
    logic bits[7];
    logic r;
    bits[0] = 1'b0;
    for (int i = 0; i < 4; i++) bits[i+1] = data[i];
    bits[5] = (^data) ^ par_flip;
    bits[6] = stop;
    for (int b = 0; b < 7; b++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        r = (rmode == 1) ? 1'($urandom_range(0, 1)) : rdy_body;
        step(1'b0, (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)), r, 1'b1);
      end
      if (rmode == 1) r = 1'($urandom_range(0, 1));
      else r = (b == 6) ? rdy_stop : rdy_body;
      step(1'b1, bits[b], r, 1'b1);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) step(i[0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (nib_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", nib_valid); end
    tests_run++;
    if (nib_out !== 4'h0) begin tests_failed++; $display("FAIL reset_nib got %h want 0", nib_out); end
    tests_run++;
    if ((n_par + n_frm + n_ovr) !== 0) begin
      tests_failed++; $display("FAIL reset_pulses got %0d want 0", n_par + n_frm + n_ovr);
    end
  endtask

  task automatic test_good_frame;
    send_frame(4'h5, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    tests_run++;
    if (nib_valid !== 1'b1 || nib_out !== 4'h5) begin
      tests_failed++; $display("FAIL good_latency got v=%b n=%h want v=1 n=5", nib_valid, nib_out);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (nib_valid !== 1'b1 || nib_out !== 4'h5) begin
      tests_failed++; $display("FAIL good_hold got v=%b n=%h want v=1 n=5", nib_valid, nib_out);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (nib_valid !== 1'b0 || nib_out !== 4'h5) begin
      tests_failed++; $display("FAIL good_accept got v=%b n=%h want v=0 n=5", nib_valid, nib_out);
    end
  endtask

  task automatic test_parity;
    send_frame(4'h7, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0);
    tests_run++;
    if (par_err !== 1'b1 || nib_valid !== 1'b0) begin
      tests_failed++; $display("FAIL par_pulse got p=%b v=%b want p=1 v=0", par_err, nib_valid);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (par_err !== 1'b0) begin tests_failed++; $display("FAIL par_width got %b want 0", par_err); end
    send_frame(4'h7, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
    tests_run++;
    if (nib_valid !== 1'b1 || nib_out !== 4'h7) begin
      tests_failed++; $display("FAIL par_good got v=%b n=%h want v=1 n=7", nib_valid, nib_out);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_framing;
    send_frame(4'h5, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tests_run++;
    if (frm_err !== 1'b1 || nib_valid !== 1'b0 || par_err !== 1'b0) begin
      tests_failed++; $display("FAIL frm_pulse got f=%b v=%b p=%b want f=1 v=0 p=0", frm_err, nib_valid, par_err);
    end
    send_frame(4'hA, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    tests_run++;
    if (nib_valid !== 1'b1 || nib_out !== 4'hA || frm_err !== 1'b0) begin
      tests_failed++; $display("FAIL frm_next got v=%b n=%h f=%b want v=1 n=a f=0", nib_valid, nib_out, frm_err);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_overrun;
    send_frame(4'h3, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    tests_run++;
    if (ovr_err !== 1'b1 || nib_out !== 4'h3 || nib_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_pulse got o=%b n=%h v=%b want o=1 n=3 v=1", ovr_err, nib_out, nib_valid);
    end
    send_frame(4'hC, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    tests_run++;
    if (ovr_err !== 1'b0 || nib_out !== 4'hC || nib_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_swap got o=%b n=%h v=%b want o=0 n=c v=1", ovr_err, nib_out, nib_valid);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int errs0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (nib_valid !== 1'b0 || nib_out !== 4'h0) begin
      tests_failed++; $display("FAIL midreset got v=%b n=%h want v=0 n=0", nib_valid, nib_out);
    end
    errs0 = n_par + n_frm + n_ovr;
    valid_cycles = 0;
    acc_q.delete(); acc_msb_q.delete();
    send_frame(4'h9, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1);
    send_frame(4'h6, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (valid_cycles !== 2) begin tests_failed++; $display("FAIL b2b_valid_cycles got %0d want 2", valid_cycles); end
    tests_run++;
    if (acc_q.size() != 2 || acc_q[0] !== 4'h9 || acc_q[1] !== 4'h6) begin
      tests_failed++; $display("FAIL b2b_lsb got %0d items first %h want 2 items 9,6", acc_q.size(),
                               (acc_q.size() > 0) ? acc_q[0] : 4'hx);
    end
    tests_run++;
    if (acc_msb_q.size() != 2 || acc_msb_q[0] !== 4'h9 || acc_msb_q[1] !== 4'h6) begin
      tests_failed++; $display("FAIL b2b_msb got %0d items first %h want 2 items 9,6", acc_msb_q.size(),
                               (acc_msb_q.size() > 0) ? acc_msb_q[0] : 4'hx);
    end
    tests_run++;
    if ((n_par + n_frm + n_ovr) !== errs0) begin
      tests_failed++; $display("FAIL b2b_errors got %0d want %0d", n_par + n_frm + n_ovr, errs0);
    end
  endtask

  task automatic test_msb_first;
    logic [3:0] d;
    d = 4'($urandom_range(0, 15));
    send_frame(d, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
    tests_run++;
    if (nib_out_m !== {d[0], d[1], d[2], d[3]} || nib_valid_m !== 1'b1) begin
      tests_failed++; $display("FAIL msb_order got %h want %h", nib_out_m, {d[0], d[1], d[2], d[3]});
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int f = 0; f < 60; f++) begin
      logic [3:0] d;
      logic pf, st;
      d  = 4'($urandom_range(0, 15));
      pf = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) != 0);
      send_frame(d, pf, st, 2, 1, 1'b0, 1'b0);
      if (nib_valid !== m_valid || nib_out !== m_nib || nib_out_m !== m_nib_msb) bad++;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL random_buffer got %0d bad frames want 0", bad); end
    tests_run++;
    if (pulse_diff !== 0) begin tests_failed++; $display("FAIL pulse_timing got %0d bad cycles want 0", pulse_diff); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity;
    test_framing;
    test_overrun;
    test_back_to_back;
    test_msb_first;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
